mc_control_fsm: RTL and testbench



---
 rtl/mc_control_fsm_if.sv | 48 ++++
 rtl/mc_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
//   Bundles the control FSM's datapath-facing signals.
//   master : the control FSM (takes opcode/zero, drives strobes and selects)
//   slave  : the datapath / instruction register side
//   Signals:
//     opcode[5:0]   instr[31:26] from the instruction register
//     zero          ALU zero flag
//     pc_en         pc_write | (branch & zero)
//     pc_write, branch, ir_write, mem_write, reg_write   write strobes
//     iord, reg_dst, mem_to_reg, alu_src_a               1-bit selects
//     alu_src_b[1:0], alu_op[1:0], pc_src[1:0]           2-bit selects
//     retire        final cycle of a legal instruction
//     illegal_op    sticky unknown-opcode flag
//     state[3:0]    current state code, for debug
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en;
  logic       pc_write;
  logic       branch;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       retire;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero,
    output pc_en, pc_write, branch, ir_write, mem_write, reg_write,
           iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, retire, illegal_op, state
  );

  modport slave (
    output opcode, zero,
    input  pc_en, pc_write, branch, ir_write, mem_write, reg_write,
           iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, retire, illegal_op, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Moore-style main control FSM for the multicycle MIPS-subset core.
//   Ports:
//     clock  : sole clock, rising edge
//     reset  : synchronous, active-high
//     bus    : mc_control_fsm_if.master (opcode/zero in, strobes/selects out)
//   Every output is decoded from the registered state; only pc_en also
//   looks at zero. While reset is high the write strobes, pc_en and retire
//   are held low and the selects show their FETCH values.
module mc_control_fsm (
  input  logic              clock,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Kept as a plain vector so codes 12-15 are representable and can be
  // recovered from (they fall into the default arm below).
  logic [3:0] state_reg;
  logic       illegal_op_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= FETCH;
      illegal_op_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH:   state_reg <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_reg <= MEMADR;
            OP_RTYPE:     state_reg <= EXECUTE;
            OP_BEQ:       state_reg <= BRANCH;
            OP_ADDI:      state_reg <= ADDIEX;
            OP_J:         state_reg <= JUMP;
            default: begin
              state_reg      <= FETCH;
              illegal_op_reg <= 1'b1;
            end
          endcase
        end
        // IR still holds LW or SW here, so only SW needs to be recognised.
        MEMADR:  state_reg <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   state_reg <= MEMWB;
        EXECUTE: state_reg <= ALUWB;
        ADDIEX:  state_reg <= ADDIWB;
        default: state_reg <= FETCH;
      endcase
    end
  end

  // Reset makes the decoder present FETCH selects regardless of the
  // register's value; the strobes are separately gated off below.
  logic [3:0] dec_state;
  assign dec_state = reset ? FETCH : state_reg;

  logic       pc_write_d;
  logic       branch_d;
  logic       ir_write_d;
  logic       mem_write_d;
  logic       reg_write_d;
  logic       retire_d;
  logic       iord_d;
  logic       reg_dst_d;
  logic       mem_to_reg_d;
  logic       alu_src_a_d;
  logic [1:0] alu_src_b_d;
  logic [1:0] alu_op_d;
  logic [1:0] pc_src_d;

  always_comb begin
    pc_write_d   = 1'b0;
    branch_d     = 1'b0;
    ir_write_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    retire_d     = 1'b0;
    iord_d       = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_op_d     = 2'b00;
    pc_src_d     = 2'b00;
    case (dec_state)
      FETCH: begin
        ir_write_d  = 1'b1;
        pc_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      DECODE: alu_src_b_d = 2'b11;
      MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      MEMRD: iord_d = 1'b1;
      MEMWB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
        retire_d     = 1'b1;
      end
      MEMWR: begin
        iord_d      = 1'b1;
        mem_write_d = 1'b1;
        retire_d    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b10;
      end
      ALUWB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
        retire_d    = 1'b1;
      end
      BRANCH: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b01;
        pc_src_d    = 2'b01;
        branch_d    = 1'b1;
        retire_d    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      ADDIWB: begin
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
      end
      JUMP: begin
        pc_src_d   = 2'b10;
        pc_write_d = 1'b1;
        retire_d   = 1'b1;
      end
      default: ;
    endcase
  end

  logic pc_write_g;
  logic branch_g;

  assign pc_write_g     = pc_write_d & ~reset;
  assign branch_g       = branch_d & ~reset;

  assign bus.pc_write   = pc_write_g;
  assign bus.branch     = branch_g;
  assign bus.pc_en      = pc_write_g | (branch_g & bus.zero);
  assign bus.ir_write   = ir_write_d & ~reset;
  assign bus.mem_write  = mem_write_d & ~reset;
  assign bus.reg_write  = reg_write_d & ~reset;
  assign bus.retire     = retire_d & ~reset;
  assign bus.iord       = iord_d;
  assign bus.reg_dst    = reg_dst_d;
  assign bus.mem_to_reg = mem_to_reg_d;
  assign bus.alu_src_a  = alu_src_a_d;
  assign bus.alu_src_b  = alu_src_b_d;
  assign bus.alu_op     = alu_op_d;
  assign bus.pc_src     = pc_src_d;
  assign bus.illegal_op = illegal_op_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Self-checking bench for mc_control_fsm. A reference model expands each
//   opcode into its expected state trace and looks up the per-state output
//   table; randomized opcodes and zero values are checked cycle by cycle.
module tb_mc_control_fsm;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic ill_model;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Bits cleared while reset is high: pc_en, pc_write, branch, ir_write,
  // mem_write, reg_write, retire.
  localparam logic [16:0] STROBE_MASK = 17'h1F801;

  typedef int trace_t[$];

  function automatic trace_t trace_for(input logic [5:0] op);
    trace_t t;
    case (op)
      OP_LW:   t = '{0, 1, 2, 3, 4};
      OP_SW:   t = '{0, 1, 2, 5};
      OP_R:    t = '{0, 1, 6, 7};
      OP_ADDI: t = '{0, 1, 9, 10};
      OP_BEQ:  t = '{0, 1, 8};
      OP_J:    t = '{0, 1, 11};
      default: t = '{0, 1};
    endcase
    return t;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Output vector: {pc_en, pc_write, branch, ir_write, mem_write, reg_write,
  //  iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0],
  //  pc_src[1:0], retire}
  function automatic logic [16:0] exp_vec(input int s, input logic z);
    logic pw, br, irw, mw, rw, io, rd, m2r, asa, ret;
    logic [1:0] asb, aop, psrc;
    {pw, br, irw, mw, rw, io, rd, m2r, asa, ret} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin irw = 1; pw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin io = 1; mw = 1; ret = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; ret = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; ret = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin rw = 1; ret = 1; end
      11: begin psrc = 2'b10; pw = 1; ret = 1; end
      default: ;
    endcase
    return {pw | (br & z), pw, br, irw, mw, rw, io, rd, m2r, asa, asb, aop, psrc, ret};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.pc_en, bus.pc_write, bus.branch, bus.ir_write, bus.mem_write,
            bus.reg_write, bus.iord, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src, bus.retire};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = OP_J;
    for (int i = 0; i < 4; i++) begin
      bus.zero = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      total++;
      if (bus.state !== 4'd0 || obs_vec() !== (exp_vec(0, bus.zero) & ~STROBE_MASK)) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d state=%0d outs=%h expected state=0 outs=%h",
                 i, bus.state, obs_vec(), exp_vec(0, bus.zero) & ~STROBE_MASK);
      end
    end
    reset = 1'b0;
    ill_model = 1'b0;
    #1;
    total++;
    if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1 || bus.illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset_release ir_write=%b pc_write=%b illegal=%b expected 1 1 0",
               bus.ir_write, bus.pc_write, bus.illegal_op);
    end
    @(posedge clock); #1;
    total++;
    if (bus.state !== 4'd1) begin
      bad++;
      $display("FAIL reset_decode state=%0d expected 1", bus.state);
    end
    @(posedge clock); #1;   // JUMP
    @(posedge clock); #1;   // back to FETCH
    $display("reset: held 4 cycles, released, decode reached");
  endtask

  task automatic test_sequence();
    logic [5:0] ops [5];
    int retires;
    int cycles;
    trace_t tr;
    ops = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_J};
    retires = 0;
    cycles = 0;
    foreach (ops[n]) begin
      bus.opcode = ops[n];
      tr = trace_for(ops[n]);
      for (int k = 0; k < tr.size(); k++) begin
        bus.zero = 1'($urandom_range(0, 1));
        #1;
        total++;
        if (bus.state !== 4'(tr[k]) || obs_vec() !== exp_vec(tr[k], bus.zero) ||
            bus.illegal_op !== ill_model) begin
          bad++;
          $display("FAIL seq op=%b cyc=%0d state=%0d outs=%h ill=%b expected state=%0d outs=%h ill=%b",
                   ops[n], k, bus.state, obs_vec(), bus.illegal_op, tr[k],
                   exp_vec(tr[k], bus.zero), ill_model);
        end
        if (bus.retire === 1'b1) retires++;
        cycles++;
        @(posedge clock); #1;
      end
      $display("seq: op=%b cycles=%0d", ops[n], tr.size());
    end
    total++;
    if (retires != 5 || cycles != 20) begin
      bad++;
      $display("FAIL seq_retire_count retires=%0d cycles=%0d expected 5 in 20", retires, cycles);
    end
  endtask

  task automatic test_branch();
    logic zv [2];
    trace_t tr;
    zv = '{1'b1, 1'b0};
    for (int n = 0; n < 2; n++) begin
      bus.opcode = OP_BEQ;
      tr = trace_for(OP_BEQ);
      for (int k = 0; k < tr.size(); k++) begin
        bus.zero = (tr[k] == 8) ? zv[n] : 1'($urandom_range(0, 1));
        #1;
        total++;
        if (bus.state !== 4'(tr[k]) || obs_vec() !== exp_vec(tr[k], bus.zero)) begin
          bad++;
          $display("FAIL beq z=%b cyc=%0d state=%0d outs=%h expected state=%0d outs=%h",
                   zv[n], k, bus.state, obs_vec(), tr[k], exp_vec(tr[k], bus.zero));
        end
        if (tr[k] == 8) begin
          total++;
          if (bus.pc_en !== zv[n] || bus.pc_src !== 2'b01 || bus.alu_op !== 2'b01) begin
            bad++;
            $display("FAIL beq_branch pc_en=%b pc_src=%b alu_op=%b expected %b 01 01",
                     bus.pc_en, bus.pc_src, bus.alu_op, zv[n]);
          end
        end
        @(posedge clock); #1;
      end
      $display("beq: zero=%b pc_en=%b", zv[n], zv[n]);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2];
    trace_t tr;
    int writes;
    ops = '{6'b111111, OP_LW};
    writes = 0;
    foreach (ops[n]) begin
      bus.opcode = ops[n];
      tr = trace_for(ops[n]);
      for (int k = 0; k < tr.size(); k++) begin
        bus.zero = 1'($urandom_range(0, 1));
        #1;
        total++;
        if (bus.state !== 4'(tr[k]) || obs_vec() !== exp_vec(tr[k], bus.zero) ||
            bus.illegal_op !== ill_model) begin
          bad++;
          $display("FAIL illegal op=%b cyc=%0d state=%0d outs=%h ill=%b expected state=%0d outs=%h ill=%b",
                   ops[n], k, bus.state, obs_vec(), bus.illegal_op, tr[k],
                   exp_vec(tr[k], bus.zero), ill_model);
        end
        if (n == 0 && (bus.mem_write === 1'b1 || bus.reg_write === 1'b1 ||
                       (k > 0 && (bus.pc_write === 1'b1 || bus.ir_write === 1'b1))))
          writes++;
        if (tr[k] == 1 && !is_legal(ops[n])) ill_model = 1'b1;
        @(posedge clock); #1;
      end
    end
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b1 || writes != 0) begin
      bad++;
      $display("FAIL illegal_sticky state=%0d ill=%b stray_writes=%0d expected 0 1 0",
               bus.state, bus.illegal_op, writes);
    end
    $display("illegal: op=111111 flagged, LW followed");
  endtask

  task automatic test_reset_mid();
    trace_t tr;
    int rw_seen;
    rw_seen = 0;
    bus.opcode = OP_LW;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.state !== 4'd3 || obs_vec() !== (exp_vec(0, bus.zero) & ~STROBE_MASK)) begin
      bad++;
      $display("FAIL reset_mid_hold state=%0d outs=%h expected state=3 outs=%h",
               bus.state, obs_vec(), exp_vec(0, bus.zero) & ~STROBE_MASK);
    end
    if (bus.reg_write === 1'b1) rw_seen++;
    @(posedge clock); #1;
    if (bus.reg_write === 1'b1) rw_seen++;
    total++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0 || rw_seen != 0) begin
      bad++;
      $display("FAIL reset_mid_abort state=%0d ill=%b reg_writes=%0d expected 0 0 0",
               bus.state, bus.illegal_op, rw_seen);
    end
    reset = 1'b0;
    ill_model = 1'b0;
    tr = trace_for(OP_LW);
    for (int k = 0; k < tr.size(); k++) begin
      bus.zero = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (bus.state !== 4'(tr[k]) || obs_vec() !== exp_vec(tr[k], bus.zero)) begin
        bad++;
        $display("FAIL reset_mid_restart cyc=%0d state=%0d outs=%h expected state=%0d outs=%h",
                 k, bus.state, obs_vec(), tr[k], exp_vec(tr[k], bus.zero));
      end
      @(posedge clock); #1;
    end
    $display("reset_mid: LW aborted in MEMRD and restarted");
  endtask

  task automatic test_random();
    logic [5:0] pool [6];
    logic [5:0] op;
    trace_t tr;
    pool = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 5)];
      bus.opcode = op;
      tr = trace_for(op);
      for (int k = 0; k < tr.size(); k++) begin
        bus.zero = 1'($urandom_range(0, 1));
        #1;
        total++;
        if (bus.state !== 4'(tr[k]) || obs_vec() !== exp_vec(tr[k], bus.zero) ||
            bus.illegal_op !== ill_model) begin
          bad++;
          $display("FAIL rand n=%0d op=%b cyc=%0d state=%0d outs=%h ill=%b expected state=%0d outs=%h ill=%b",
                   n, op, k, bus.state, obs_vec(), bus.illegal_op, tr[k],
                   exp_vec(tr[k], bus.zero), ill_model);
        end
        if (tr[k] == 1 && !is_legal(op)) ill_model = 1'b1;
        @(posedge clock); #1;
      end
      $display("rand: n=%0d op=%b cycles=%0d", n, op, tr.size());
    end
  endtask

  task automatic test_bad_state();
    dut.state_reg = 4'd13;
    bus.zero = 1'b1;
    #1;
    total++;
    if (bus.state !== 4'd13 || obs_vec() !== 17'h0) begin
      bad++;
      $display("FAIL bad_state_outs state=%0d outs=%h expected state=13 outs=0",
               bus.state, obs_vec());
    end
    @(posedge clock); #1;
    total++;
    if (bus.state !== 4'd0 || obs_vec() !== exp_vec(0, bus.zero)) begin
      bad++;
      $display("FAIL bad_state_recover state=%0d outs=%h expected state=0 outs=%h",
               bus.state, obs_vec(), exp_vec(0, bus.zero));
    end
    $display("bad_state: code 13 recovered to FETCH");
  endtask

  initial begin
    total = 0;
    bad = 0;
    ill_model = 1'b0;
    reset = 1'b1;
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    test_reset();
    test_sequence();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_random();
    test_bad_state();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
